// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding and read-latency limits.
// No logic of its own; the latency loader clamps out-of-range settings into the legal window.
// Imported by mem_arbiter and its round-robin picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 7;
    localparam int LAT_CNT_W  = 3;

    // Counter preload for the WAIT phase: RD_LAT-1, with RD_LAT forced into 1..7.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int rd_lat);
        int v;
        v = rd_lat;
        if (v < RD_LAT_MIN) v = RD_LAT_MIN;
        if (v > RD_LAT_MAX) v = RD_LAT_MAX;
        return LAT_CNT_W'(v - 1);
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: lone requester wins, on contention the port that did not win last time.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    // Winner is port 1 only if it asks alone, or both ask and port 0 won the last contest.
    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? ~last : req1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU (port 0) and loader/debug (port 1) onto one single-ported memory, one access at a time.
// Latency: gnt 1 cycle after req is sampled in IDLE; write busy 2 cycles; rvalid RD_LAT+2 cycles after sampling.
// Backpressure: requests are only sampled in IDLE; a requester holds req until it sees its gnt.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam logic [LAT_CNT_W-1:0] LAT_PRELOAD = lat_load(RD_LAT);

    arb_state_t           state;
    logic                 last;
    logic                 win;
    logic                 acc_we;
    logic [LAT_CNT_W-1:0] lat_cnt;

    logic                 pick_vld;
    logic                 pick_win;
    req_t                 pick_req;

    arb_rr2 u_rr (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .valid  (pick_vld),
        .winner (pick_win)
    );

    // Steer the winning port's command onto a single bundle for latching.
    always_comb begin
        pick_req.we    = pick_win ? we1    : we0;
        pick_req.addr  = pick_win ? addr1  : addr0;
        pick_req.wdata = pick_win ? wdata1 : wdata0;
    end

    // Access sequencer; every output is a register so nothing from req reaches a port combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            last      <= 1'b1;
            win       <= 1'b0;
            acc_we    <= 1'b0;
            lat_cnt   <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mem_we  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state     <= ST_ACCESS;
                        win       <= pick_win;
                        // Fairness pointer only moves when both ports actually competed.
                        if (req0 && req1) last <= pick_win;
                        acc_we    <= pick_req.we;
                        mem_addr  <= pick_req.addr;
                        mem_wdata <= pick_req.wdata;
                        mem_we    <= pick_req.we;
                        gnt0      <= ~pick_win;
                        gnt1      <= pick_win;
                        busy      <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (acc_we) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= ST_WAIT;
                        lat_cnt <= LAT_PRELOAD;
                    end
                end
                ST_WAIT: begin
                    // mem_addr is left untouched here so the memory sees a stable address.
                    if (lat_cnt == '0) begin
                        state <= ST_RESP;
                        if (win) begin
                            rdata1  <= mem_rdata;
                            rvalid1 <= 1'b1;
                        end else begin
                            rdata0  <= mem_rdata;
                            rvalid0 <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: random two-port traffic against a transaction-level model plus directed corners.
// Latency: expectations derive from gnt at sample+1 and rvalid at sample+RD_LAT+2.
// Backpressure: drivers hold req until their gnt, then drop it.
module tb_mem_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int RDL = 2;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            cyc;
    } rd_exp_t;

    logic          clk;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Latency-sweep instances: memory data is the cycle number, so captured data exposes capture time.
    logic          sw_req;
    logic [DW-1:0] sw_mrd;
    logic          g0_1, g1_1, v0_1, v1_1, we_1, b_1;
    logic          g0_7, g1_7, v0_7, v1_7, we_7, b_7;
    logic [DW-1:0] rd0_1, rd1_1, wd_1, rd0_7, rd1_7, wd_7;
    logic [AW-1:0] ma_1, ma_7;

    assign sw_mrd = 32'hA500_0000 | 32'(cyc);

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .req0(sw_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(10'h3FF), .addr1(10'h000), .wdata0(32'h0), .wdata1(32'h0),
        .gnt0(g0_1), .gnt1(g1_1), .rvalid0(v0_1), .rvalid1(v1_1),
        .rdata0(rd0_1), .rdata1(rd1_1),
        .mem_addr(ma_1), .mem_wdata(wd_1), .mem_we(we_1),
        .mem_rdata(sw_mrd), .busy(b_1)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(7)) u_lat7 (
        .clk(clk), .reset(reset),
        .req0(sw_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(10'h3FF), .addr1(10'h000), .wdata0(32'h0), .wdata1(32'h0),
        .gnt0(g0_7), .gnt1(g1_7), .rvalid0(v0_7), .rvalid1(v1_7),
        .rdata0(rd0_7), .rdata1(rd1_7),
        .mem_addr(ma_7), .mem_wdata(wd_7), .mem_we(we_7),
        .mem_rdata(sw_mrd), .busy(b_7)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Physical memory: writes commit at the edge, reads return RDL cycles after the address is driven.
    bit   [DW-1:0] mem_arr [1024];
    logic [DW-1:0] rd_pipe [RDL];
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem_arr[mem_addr];
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RDL-1];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model and monitor ----------------
    txn_t    pq0[$];
    txn_t    pq1[$];
    rd_exp_t rq[$];
    bit [DW-1:0] mmem [1024];
    logic [DW-1:0] exp_rd [2];
    txn_t    cur;
    logic [DW-1:0] cur_rd;
    int      mcyc = 0;
    int      busy_until = 0;
    int      exp_gnt = -1;
    int      last_m = 1;
    int      win_m;
    bit      armed = 0;
    bit      chk_rst = 0;
    logic [1:0] exp_rv;

    // Transaction-level model: arbitration outcome, memory contents and response timing per sampled request.
    always @(negedge clk) begin
        mcyc++;
        if (chk_rst) begin
            chk("rst_ctrl", 32'({gnt0, gnt1, rvalid0, rvalid1, mem_we, busy}), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_rdata0", rdata0, 32'd0);
            chk("rst_rdata1", rdata1, 32'd0);
            chk_rst = 0;
        end
        if (reset) begin
            armed      = 1;
            chk_rst    = 1;
            rq.delete();
            busy_until = mcyc;
            exp_gnt    = -1;
            last_m     = 1;
            exp_rd[0]  = '0;
            exp_rd[1]  = '0;
        end else if (armed) begin
            chk("gnt", 32'({gnt1, gnt0}), 32'({exp_gnt == 1, exp_gnt == 0}));
            chk("mem_we", 32'(mem_we), 32'(exp_gnt >= 0 && cur.we));
            if (exp_gnt >= 0) begin
                chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
                chk("mem_wdata", mem_wdata, cur.wdata);
                if (cur.we) begin
                    busy_until = mcyc;
                end else begin
                    busy_until = mcyc + 1 + RDL;
                    rq.push_back('{exp_gnt, cur_rd, busy_until});
                end
            end
            exp_rv = 2'b00;
            if (rq.size() > 0 && rq[0].cyc == mcyc) exp_rv[rq[0].port] = 1'b1;
            chk("rvalid", 32'({rvalid1, rvalid0}), 32'(exp_rv));
            if (exp_rv != 2'b00) begin
                exp_rd[rq[0].port] = rq[0].data;
                void'(rq.pop_front());
            end
            chk("rdata0", rdata0, exp_rd[0]);
            chk("rdata1", rdata1, exp_rd[1]);
            chk("busy", 32'(busy), 32'(mcyc <= busy_until));
            // Predict the grant for requests sampled while the arbiter is idle this cycle.
            exp_gnt = -1;
            if (mcyc > busy_until && (req0 || req1)) begin
                if (req0 && req1) begin
                    win_m  = (last_m == 0) ? 1 : 0;
                    last_m = win_m;
                end else begin
                    win_m = req1 ? 1 : 0;
                end
                if ((win_m == 0 && pq0.size() == 0) || (win_m == 1 && pq1.size() == 0)) begin
                    chk("model_queue", 32'd0, 32'd1);
                end else begin
                    cur = (win_m == 0) ? pq0.pop_front() : pq1.pop_front();
                    if (cur.we) mmem[cur.addr] = cur.wdata;
                    else        cur_rd = mmem[cur.addr];
                    exp_gnt = win_m;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        int   waited;
        bit   seen;
        t = '{we, a, d};
        @(posedge clk); #1;
        if (p == 0) begin
            pq0.push_back(t); we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
        end else begin
            pq1.push_back(t); we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
        end
        waited = 0;
        seen   = 0;
        while (!seen && waited < 100) begin
            @(posedge clk); #1;
            waited++;
            seen = (p == 0) ? gnt0 : gnt1;
        end
        chk($sformatf("gnt_wait_p%0d", p), 32'(seen), 32'd1);
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    task automatic port_driver(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            issue(p, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
        end
    endtask

    int s, g1, g7, r1, r7, n1, n7, nb;
    logic [DW-1:0] d1, d7;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sw_req = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Single write then single read back from the other port.
        issue(0, 1'b1, 10'h010, 32'hDEADBEEF);
        issue(1, 1'b0, 10'h010, 32'h0);
        repeat (6) @(posedge clk);

        // Contention: both ports re-request after every grant.
        fork
            begin issue(0, 1'b0, 10'h010, 32'h1); issue(0, 1'b1, 10'h011, 32'h1111_0000); end
            begin issue(1, 1'b1, 10'h012, 32'h2222_0000); issue(1, 1'b0, 10'h011, 32'h2); end
        join
        repeat (6) @(posedge clk);

        // Port 0 raises req while a port-1 read is in flight.
        fork
            issue(1, 1'b0, 10'h012, 32'h3);
            begin @(posedge clk); issue(0, 1'b1, 10'h013, 32'h4444_4444); end
        join
        repeat (6) @(posedge clk);

        // Random mixed traffic from both ports.
        fork
            port_driver(0, 40);
            port_driver(1, 40);
        join
        repeat (20) @(posedge clk);

        // Reset during the first WAIT cycle of a port-1 read, then a normal read.
        issue(1, 1'b0, 10'h010, 32'h0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        issue(0, 1'b0, 10'h010, 32'h0);
        repeat (10) @(posedge clk);

        // Latency sweep on RD_LAT=1 and RD_LAT=7 instances.
        @(posedge clk); #1;
        sw_req = 1'b1;
        s = cyc;
        g1 = -1; g7 = -1; r1 = -1; r7 = -1; n1 = 0; n7 = 0; nb = 0; d1 = '0; d7 = '0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (g0_1 && g1 < 0) g1 = cyc;
            if (g0_7 && g7 < 0) g7 = cyc;
            if (g1 >= 0 && g7 >= 0) sw_req = 1'b0;
            if (v0_1) begin r1 = cyc; d1 = rd0_1; n1++; end
            if (v0_7) begin r7 = cyc; d7 = rd0_7; n7++; end
            if (g1_1 || g1_7 || v1_1 || v1_7) nb++;
        end
        sw_req = 1'b0;
        chk("lat1_gnt_cycle", 32'(g1), 32'(s + 1));
        chk("lat7_gnt_cycle", 32'(g7), 32'(s + 1));
        chk("lat1_rvalid_cycle", 32'(r1), 32'(s + 3));
        chk("lat7_rvalid_cycle", 32'(r7), 32'(s + 9));
        chk("lat1_rdata", d1, 32'hA500_0000 | 32'(s + 2));
        chk("lat7_rdata", d7, 32'hA500_0000 | 32'(s + 8));
        chk("lat1_rvalid_pulses", 32'(n1), 32'd1);
        chk("lat7_rvalid_pulses", 32'(n7), 32'd1);
        chk("sweep_port1_quiet", 32'(nb), 32'd0);

        chk("pq0_drained", 32'(pq0.size()), 32'd0);
        chk("pq1_drained", 32'(pq1.size()), 32'd0);
        chk("reads_drained", 32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
